// File: rtl/spike_rate_decoder_if.sv
// Result/control bundle between the spike rate decoder and its host.
// The host drives enable, the spike level and ready; the decoder returns a valid result and the overrun flag.
interface spike_rate_decoder_if #(
    parameter int CNT_W = 5,
    parameter int ISI_W = 8
);
    logic             en;
    logic             spike_in;
    logic             out_ready;
    logic             out_valid;
    logic [CNT_W-1:0] rate_out;
    logic [ISI_W-1:0] isi_out;
    logic             overrun;

    modport master (
        output en, spike_in, out_ready,
        input  out_valid, rate_out, isi_out, overrun
    );

    modport slave (
        input  en, spike_in, out_ready,
        output out_valid, rate_out, isi_out, overrun
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts rising spike edges per fixed window and tracks the last inter-spike interval.
// Each completed window is offered through a single-entry valid/ready result register.
//
//  state | meaning
//  IDLE  | decoding off, all counters held at zero
//  RUN   | window running, one result per WINDOW cycles
module spike_rate_decoder #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5,
    parameter int ISI_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    spike_rate_decoder_if.slave  bus
);
    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [ISI_W-1:0] ISI_MAX  = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic               run;
    logic               spike_q;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   edge_cnt;
    logic [ISI_W-1:0]   isi_cnt;
    logic [ISI_W-1:0]   last_isi;
    logic               seen;

    logic               edge_det;
    logic               win_end;
    logic               slot_free;
    logic [CNT_W-1:0]   edge_cnt_next;
    logic [ISI_W-1:0]   last_isi_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Dropping en in any RUN cycle abandons the partial window.
    always_comb begin
        state_next = state;
        run        = 1'b0;
        case (state)
            IDLE: if (bus.en) state_next = RUN;
            RUN: begin
                if (bus.en) run = 1'b1;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign edge_det      = bus.spike_in & ~spike_q;
    assign win_end       = run && (win_cnt == WIN_LAST);
    assign slot_free     = ~bus.out_valid | bus.out_ready;
    assign edge_cnt_next = edge_cnt + CNT_W'(edge_det);
    assign last_isi_next = (edge_det && seen) ? isi_cnt : last_isi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q  <= 1'b0;
            win_cnt  <= '0;
            edge_cnt <= '0;
            isi_cnt  <= '0;
            last_isi <= '0;
            seen     <= 1'b0;
        end else begin
            spike_q <= bus.spike_in;
            if (!run) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
                isi_cnt  <= '0;
                last_isi <= '0;
                seen     <= 1'b0;
            end else begin
                win_cnt  <= win_end ? '0 : win_cnt + WIN_W'(1);
                edge_cnt <= win_end ? '0 : edge_cnt_next;
                if (edge_det)               isi_cnt <= ISI_W'(1);
                else if (isi_cnt != ISI_MAX) isi_cnt <= isi_cnt + ISI_W'(1);
                last_isi <= last_isi_next;
                seen     <= seen | edge_det;
            end
        end
    end

    // A window that completes while the previous result is still stalled is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.rate_out  <= '0;
            bus.isi_out   <= '0;
            bus.overrun   <= 1'b0;
        end else if (win_end) begin
            if (slot_free) begin
                bus.out_valid <= 1'b1;
                bus.rate_out  <= edge_cnt_next;
                bus.isi_out   <= last_isi_next;
            end else begin
                bus.overrun   <= 1'b1;
            end
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a default instance plus a narrow-ISI instance for saturation.
// Expected window results are queued when stimulus is driven and compared on each handshake.
module tb_spike_rate_decoder;
    logic clk = 1'b0;
    logic rst;

    spike_rate_decoder_if #(.CNT_W(5), .ISI_W(8)) sif ();
    spike_rate_decoder_if #(.CNT_W(5), .ISI_W(4)) sif4 ();

    spike_rate_decoder #(.WINDOW(16), .CNT_W(5), .ISI_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    spike_rate_decoder #(.WINDOW(16), .CNT_W(5), .ISI_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (sif4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rate;
        logic [7:0] isi;
    } res_t;

    res_t exp_q[$];
    res_t sb_e;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of p is the spike level on window cycle i.
    task automatic run(input logic [15:0] p, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            sif.spike_in  = p[i];
            sif4.spike_in = p[i];
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && sif.out_valid && sif.out_ready) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed rate %0d isi %0d expected no result",
                       sif.rate_out, sif.isi_out);
            end
            if (exp_q.size() > 0) begin
                sb_e = exp_q.pop_front();
                n_assert++;
                assert ({sif.rate_out, sif.isi_out} === {sb_e.rate, sb_e.isi}) else begin
                    n_fail++;
                    $error("FAIL sb_result: observed rate %0d isi %0d expected rate %0d isi %0d",
                           sif.rate_out, sif.isi_out, sb_e.rate, sb_e.isi);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        sif.en         = 1'b0;
        sif.spike_in   = 1'b0;
        sif.out_ready  = 1'b1;
        sif4.en        = 1'b0;
        sif4.spike_in  = 1'b0;
        sif4.out_ready = 1'b1;
        #3;
        check("rst_valid",   32'(sif.out_valid), 32'd0);
        check("rst_rate",    32'(sif.rate_out),  32'd0);
        check("rst_isi",     32'(sif.isi_out),   32'd0);
        check("rst_overrun", 32'(sif.overrun),   32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // spikes on window cycles 2, 6, 10
        exp_q.push_back('{5'd3, 8'd4});
        sif.en = 1'b1;
        tick();
        run(16'h0444, 0, 14);
        check("t2_not_early", 32'(sif.out_valid), 32'd0);
        run(16'h0444, 15, 15);
        check("t2_valid", 32'(sif.out_valid), 32'd1);
        check("t2_rate",  32'(sif.rate_out),  32'd3);
        check("t2_isi",   32'(sif.isi_out),   32'd4);
        tick();
        check("t2_one_cycle", 32'(sif.out_valid), 32'd0);
        sif.en = 1'b0;
        tick();
        tick();

        // enable while spike high; level held through cycle 1, then high 3..7
        exp_q.push_back('{5'd1, 8'd0});
        sif.spike_in = 1'b1;
        sif.en       = 1'b1;
        tick();
        run(16'h00FB, 0, 15);
        check("t3_valid", 32'(sif.out_valid), 32'd1);
        check("t3_rate",  32'(sif.rate_out),  32'd1);
        sif.en       = 1'b0;
        sif.spike_in = 1'b0;
        tick();
        tick();

        // alternating spike, last edge on cycle 15
        exp_q.push_back('{5'd8, 8'd2});
        sif.en = 1'b1;
        tick();
        run(16'hAAAA, 0, 15);
        check("t5_rate", 32'(sif.rate_out), 32'd8);
        check("t5_isi",  32'(sif.isi_out),  32'd2);
        sif.en       = 1'b0;
        sif.spike_in = 1'b0;
        tick();
        tick();

        // abort at cycle 8, then fresh window with a single spike
        sif.en = 1'b1;
        tick();
        run(16'h0012, 0, 7);
        sif.en       = 1'b0;
        sif.spike_in = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("t6_no_partial", 32'(sif.out_valid), 32'd0);
        exp_q.push_back('{5'd1, 8'd0});
        sif.en = 1'b1;
        tick();
        run(16'h0020, 0, 15);
        check("t6_rate", 32'(sif.rate_out), 32'd1);
        check("t6_isi",  32'(sif.isi_out),  32'd0);
        sif.en = 1'b0;
        tick();
        tick();

        // stalled output across two window ends
        exp_q.push_back('{5'd2, 8'd4});
        sif.out_ready = 1'b0;
        sif.en        = 1'b1;
        tick();
        run(16'h0022, 0, 15);
        check("t4_valid_a",   32'(sif.out_valid), 32'd1);
        check("t4_no_ovr_a",  32'(sif.overrun),   32'd0);
        run(16'h1249, 0, 15);
        check("t4_overrun",   32'(sif.overrun),   32'd1);
        check("t4_rate_held", 32'(sif.rate_out),  32'd2);
        check("t4_isi_held",  32'(sif.isi_out),   32'd4);
        check("t4_valid_b",   32'(sif.out_valid), 32'd1);
        sif.out_ready = 1'b1;
        tick();
        check("t4_drained",   32'(sif.out_valid), 32'd0);
        check("t4_ovr_stick", 32'(sif.overrun),   32'd1);

        // refill the slot, then reset mid-window between clock edges
        sif.out_ready = 1'b0;
        run(16'h0000, 1, 15);
        check("t1_valid_pre", 32'(sif.out_valid), 32'd1);
        check("t1_rate_pre",  32'(sif.rate_out),  32'd0);
        check("t1_isi_pre",   32'(sif.isi_out),   32'd3);
        run(16'h0000, 0, 2);
        #1;
        rst = 1'b1;
        #1;
        check("t1_valid", 32'(sif.out_valid), 32'd0);
        check("t1_rate",  32'(sif.rate_out),  32'd0);
        check("t1_isi",   32'(sif.isi_out),   32'd0);
        check("t1_ovr",   32'(sif.overrun),   32'd0);
        sif.en        = 1'b0;
        sif.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // 4-bit ISI: edges 20 cycles apart saturate at 15
        sif4.en = 1'b1;
        tick();
        run(16'h0001, 0, 15);
        check("t6s_valid_a", 32'(sif4.out_valid), 32'd1);
        check("t6s_rate_a",  32'(sif4.rate_out),  32'd1);
        check("t6s_isi_a",   32'(sif4.isi_out),   32'd0);
        run(16'h0010, 0, 15);
        check("t6s_rate_b",  32'(sif4.rate_out),  32'd1);
        check("t6s_isi_sat", 32'(sif4.isi_out),   32'd15);
        sif4.en       = 1'b0;
        sif4.spike_in = 1'b0;
        sif.spike_in  = 1'b0;
        tick();
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
